sprite_anim_mapper: RTL and testbench

- Parametrised sprite renderer for the VGA path; successor to the single-image fixed-stretch mappers.
- Places an animated, integer-scaled sprite at a runtime position and drives an external synchronous sprite ROM.
- Maps ROM indices through an internal palette and composites over a background colour, with palette index 0 transparent.
- Sits between the VGA controller (DrawX/DrawY/blank) and the colour mux.

---
 rtl/sprite_anim_mapper.sv | 152 +++++++++++++++
 tb/tb_sprite_anim_mapper.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_mapper.sv
// Animated, integer-scaled sprite renderer: drives a synchronous sprite ROM and composites palette colour over bg.
// Optional MIRROR_EN adds a per-frame latched horizontal flip input.
module sprite_anim_mapper #(
   parameter int SPRITE_W   = 40,
   parameter int SPRITE_H   = 66,
   parameter int NUM_FRAMES = 4,
   parameter int SCALE_LOG2 = 1,
   parameter int FRAME_HOLD = 8,
   parameter int ADDR_W     = 15,
   parameter int IDX_W      = 4
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic              frame_tick,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic              anim_en,
`ifdef MIRROR_EN
   input  logic              mirror,
`endif
   input  logic [3:0]        bg_red,
   input  logic [3:0]        bg_green,
   input  logic [3:0]        bg_blue,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              sprite_hit
);

   localparam int FRAME_SIZE = SPRITE_W * SPRITE_H;
   localparam int W_PIX      = SPRITE_W << SCALE_LOG2;
   localparam int H_PIX      = SPRITE_H << SCALE_LOG2;
   localparam int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

   function automatic logic [11:0] palette(input logic [IDX_W-1:0] idx);
      logic [11:0] rgb;
      case (4'(idx))
         4'h0: rgb = 12'h000;
         4'h1: rgb = 12'h000;
         4'h2: rgb = 12'hFFF;
         4'h3: rgb = 12'hF00;
         4'h4: rgb = 12'h0F0;
         4'h5: rgb = 12'hF80;
         4'h6: rgb = 12'h00F;
         4'h7: rgb = 12'hFF0;
         4'h8: rgb = 12'h0FF;
         4'h9: rgb = 12'hF0F;
         4'hA: rgb = 12'h888;
         4'hB: rgb = 12'h444;
         4'hC: rgb = 12'h840;
         4'hD: rgb = 12'hFCA;
         4'hE: rgb = 12'h4A4;
         default: rgb = 12'h24F;
      endcase
      return rgb;
   endfunction

   logic [9:0]         pos_x_q, pos_y_q;
   logic               mirror_q;
   logic [FRAME_W-1:0] frame_q;
   logic [HOLD_W-1:0]  hold_q;

   // Position, mirror and animation state only move on the vsync tick.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         pos_x_q  <= '0;
         pos_y_q  <= '0;
         mirror_q <= 1'b0;
         frame_q  <= '0;
         hold_q   <= '0;
      end else if (frame_tick) begin
         pos_x_q <= sprite_x;
         pos_y_q <= sprite_y;
`ifdef MIRROR_EN
         mirror_q <= mirror;
`else
         mirror_q <= 1'b0;
`endif
         if (anim_en) begin
            if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
               hold_q  <= '0;
               frame_q <= (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
            end else begin
               hold_q <= hold_q + 1'b1;
            end
         end
      end
   end

   logic signed [10:0] dx, dy;
   logic [9:0]         lx, ly, lx_eff;
   logic               inside_c;
   logic [ADDR_W-1:0]  addr_c;

   // Signed offsets keep a wrapped position (e.g. x=1020) from drawing at the left edge.
   always_comb begin
      dx       = $signed({1'b0, DrawX}) - $signed({1'b0, pos_x_q});
      dy       = $signed({1'b0, DrawY}) - $signed({1'b0, pos_y_q});
      inside_c = !dx[10] && !dy[10] && (32'(dx[9:0]) < W_PIX) && (32'(dy[9:0]) < H_PIX);
      lx       = dx[9:0] >> SCALE_LOG2;
      ly       = dy[9:0] >> SCALE_LOG2;
      lx_eff   = mirror_q ? (10'(SPRITE_W - 1) - lx) : lx;
      addr_c   = ADDR_W'(32'(frame_q) * FRAME_SIZE + 32'(ly) * SPRITE_W + 32'(lx_eff));
   end

   logic        s0_inside, s0_blank, s1_inside, s1_blank;
   logic [11:0] s0_bg, s1_bg;

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         rom_address <= '0;
         s0_inside   <= 1'b0;
         s0_blank    <= 1'b0;
         s0_bg       <= '0;
         s1_inside   <= 1'b0;
         s1_blank    <= 1'b0;
         s1_bg       <= '0;
      end else begin
         rom_address <= inside_c ? addr_c : '0;
         s0_inside   <= inside_c;
         s0_blank    <= blank;
         s0_bg       <= {bg_red, bg_green, bg_blue};
         s1_inside   <= s0_inside;
         s1_blank    <= s0_blank;
         s1_bg       <= s0_bg;
      end
   end

   // rom_q lines up with the s1 stage; index 0 is transparent.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         {red, green, blue} <= '0;
         sprite_hit         <= 1'b0;
      end else if (!s1_blank) begin
         {red, green, blue} <= '0;
         sprite_hit         <= 1'b0;
      end else if (s1_inside && (rom_q != '0)) begin
         {red, green, blue} <= palette(rom_q);
         sprite_hit         <= 1'b1;
      end else begin
         {red, green, blue} <= s1_bg;
         sprite_hit         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Directed bench for sprite_anim_mapper; the ROM model returns rom_fill one clock after any address.
// Define MIRROR_EN to also exercise the horizontal flip.
module tb_sprite_anim_mapper;
   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX, DrawY, sprite_x, sprite_y;
   logic        blank, frame_tick, anim_en;
   logic [3:0]  bg_red, bg_green, bg_blue;
   logic [14:0] rom_address;
   logic [3:0]  rom_q;
   logic [3:0]  red, green, blue;
   logic        sprite_hit;
`ifdef MIRROR_EN
   logic        mirror;
`endif

   logic [3:0]  rom_fill;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [12:0] out_v;

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk) rom_q <= rom_fill;

   assign out_v = {red, green, blue, sprite_hit};

   sprite_anim_mapper dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_tick(frame_tick), .sprite_x(sprite_x), .sprite_y(sprite_y), .anim_en(anim_en),
`ifdef MIRROR_EN
      .mirror(mirror),
`endif
      .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue), .rom_address(rom_address),
      .rom_q(rom_q), .red(red), .green(green), .blue(blue), .sprite_hit(sprite_hit)
   );

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic settle3();
      tick(); tick(); tick();
   endtask

   task automatic pulse_tick(input int n);
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         tick();
         frame_tick = 1'b0;
         tick();
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic set_pix(input logic [9:0] x, input logic [9:0] y);
      DrawX = x;
      DrawY = y;
   endtask

   task automatic test_reset();
      reset = 1'b1; blank = 1'b1; frame_tick = 1'b0; anim_en = 1'b0;
      sprite_x = 10'd0; sprite_y = 10'd0; rom_fill = 4'd5;
      {bg_red, bg_green, bg_blue} = 12'h123;
`ifdef MIRROR_EN
      mirror = 1'b0;
`endif
      set_pix(10'd0, 10'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         n_tests++;
         if (out_v !== 13'h0 || rom_address !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_cyc%0d: out=%h addr=%0d expected out=0 addr=0", i, out_v, rom_address);
         end
      end
      reset = 1'b0;
      tick();
      n_tests++;
      if (out_v !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_first_after: out=%h expected 0", out_v);
      end
   endtask

   task automatic test_latch_address();
      sprite_x = 10'd100; sprite_y = 10'd50;
      set_pix(10'd100, 10'd50);
      pulse_tick(1);
      sprite_x = 10'd300; sprite_y = 10'd300;  // mid-frame change must not take effect
      set_pix(10'd102, 10'd50);
      tick();
      n_tests++;
      if (rom_address !== 15'd1) begin
         n_fail++; $display("FAIL addr_x102: got %0d expected 1", rom_address);
      end
      set_pix(10'd101, 10'd52);
      tick();
      n_tests++;
      if (rom_address !== 15'd40) begin
         n_fail++; $display("FAIL addr_y52: got %0d expected 40", rom_address);
      end
      set_pix(10'd179, 10'd181);
      tick();
      n_tests++;
      if (rom_address !== 15'd2639) begin
         n_fail++; $display("FAIL addr_corner: got %0d expected 2639", rom_address);
      end
      set_pix(10'd100, 10'd182);
      tick();
      n_tests++;
      if (rom_address !== 15'd0) begin
         n_fail++; $display("FAIL addr_below: got %0d expected 0", rom_address);
      end
   endtask

   task automatic test_composite();
      {bg_red, bg_green, bg_blue} = 12'hABC;
      rom_fill = 4'd0;
      set_pix(10'd100, 10'd50);
      settle3();
      n_tests++;
      if (out_v !== {12'hABC, 1'b0}) begin
         n_fail++; $display("FAIL comp_transparent: got %h expected %h", out_v, {12'hABC, 1'b0});
      end
      rom_fill = 4'd5;
      settle3();
      n_tests++;
      if (out_v !== {12'hF80, 1'b1}) begin
         n_fail++; $display("FAIL comp_opaque: got %h expected %h", out_v, {12'hF80, 1'b1});
      end
      set_pix(10'd99, 10'd50);
      settle3();
      n_tests++;
      if (out_v !== {12'hABC, 1'b0}) begin
         n_fail++; $display("FAIL comp_outside: got %h expected %h", out_v, {12'hABC, 1'b0});
      end
      set_pix(10'd100, 10'd50);
      blank = 1'b0;
      settle3();
      n_tests++;
      if (out_v !== 13'h0) begin
         n_fail++; $display("FAIL comp_blank: got %h expected 0", out_v);
      end
      blank = 1'b1;
      // Latency: the first new pixel appears on the third edge, not earlier.
      set_pix(10'd99, 10'd50);
      settle3();
      set_pix(10'd100, 10'd50);
      tick(); tick();
      n_tests++;
      if (out_v !== {12'hABC, 1'b0}) begin
         n_fail++; $display("FAIL latency_2cyc: got %h expected %h", out_v, {12'hABC, 1'b0});
      end
      tick();
      n_tests++;
      if (out_v !== {12'hF80, 1'b1}) begin
         n_fail++; $display("FAIL latency_3cyc: got %h expected %h", out_v, {12'hF80, 1'b1});
      end
   endtask

   task automatic test_animation();
      sprite_x = 10'd100; sprite_y = 10'd50;
      anim_en = 1'b1;
      pulse_tick(8);
      set_pix(10'd100, 10'd50);
      tick();
      n_tests++;
      if (rom_address !== 15'd2640) begin
         n_fail++; $display("FAIL anim_frame1: got %0d expected 2640", rom_address);
      end
      pulse_tick(8);
      set_pix(10'd102, 10'd50);
      tick();
      n_tests++;
      if (rom_address !== 15'd5281) begin
         n_fail++; $display("FAIL anim_frame2: got %0d expected 5281", rom_address);
      end
      pulse_tick(16);
      tick();
      n_tests++;
      if (rom_address !== 15'd1) begin
         n_fail++; $display("FAIL anim_wrap: got %0d expected 1", rom_address);
      end
      pulse_tick(4);
      anim_en = 1'b0;
      pulse_tick(5);
      tick();
      n_tests++;
      if (rom_address !== 15'd1) begin
         n_fail++; $display("FAIL anim_freeze: got %0d expected 1", rom_address);
      end
      anim_en = 1'b1;
      pulse_tick(4);
      tick();
      n_tests++;
      if (rom_address !== 15'd2641) begin
         n_fail++; $display("FAIL anim_resume: got %0d expected 2641", rom_address);
      end
      anim_en = 1'b0;
   endtask

   task automatic test_clipping();
      apply_reset();
      rom_fill = 4'd5;
      {bg_red, bg_green, bg_blue} = 12'h321;
      sprite_x = 10'd1020; sprite_y = 10'd50;
      pulse_tick(1);
      for (int x = 0; x <= 10; x++) begin
         set_pix(10'(x), 10'd60);
         tick();
         n_tests++;
         if (rom_address !== 15'd0) begin
            n_fail++; $display("FAIL clip_left_addr x=%0d: got %0d expected 0", x, rom_address);
         end
         tick(); tick();
         n_tests++;
         if (out_v !== {12'h321, 1'b0}) begin
            n_fail++; $display("FAIL clip_left_out x=%0d: got %h expected %h", x, out_v, {12'h321, 1'b0});
         end
      end
      sprite_x = 10'd600;
      pulse_tick(1);
      set_pix(10'd639, 10'd50);
      tick();
      n_tests++;
      if (rom_address !== 15'd19) begin
         n_fail++; $display("FAIL clip_right_639: got %0d expected 19", rom_address);
      end
      tick(); tick();
      n_tests++;
      if (out_v !== {12'hF80, 1'b1}) begin
         n_fail++; $display("FAIL clip_right_hit: got %h expected %h", out_v, {12'hF80, 1'b1});
      end
      set_pix(10'd679, 10'd50);
      tick();
      n_tests++;
      if (rom_address !== 15'd39) begin
         n_fail++; $display("FAIL clip_win_last: got %0d expected 39", rom_address);
      end
      set_pix(10'd680, 10'd51);
      tick();
      n_tests++;
      if (rom_address !== 15'd0) begin
         n_fail++; $display("FAIL clip_win_past: got %0d expected 0", rom_address);
      end
   endtask

   task automatic test_reset_midline();
      sprite_x = 10'd0; sprite_y = 10'd0;
      pulse_tick(1);
      rom_fill = 4'd5;
      set_pix(10'd0, 10'd0);
      settle3();
      n_tests++;
      if (out_v !== {12'hF80, 1'b1}) begin
         n_fail++; $display("FAIL midline_pre: got %h expected %h", out_v, {12'hF80, 1'b1});
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++;
      if (out_v !== 13'h0) begin
         n_fail++; $display("FAIL midline_in_reset: got %h expected 0", out_v);
      end
      tick();
      n_tests++;
      if (out_v !== 13'h0) begin
         n_fail++; $display("FAIL midline_stale1: got %h expected 0", out_v);
      end
      tick();
      n_tests++;
      if (out_v !== 13'h0) begin
         n_fail++; $display("FAIL midline_stale2: got %h expected 0", out_v);
      end
      tick();
      n_tests++;
      if (out_v !== {12'hF80, 1'b1}) begin
         n_fail++; $display("FAIL midline_recover: got %h expected %h", out_v, {12'hF80, 1'b1});
      end
   endtask

`ifdef MIRROR_EN
   task automatic test_mirror();
      apply_reset();
      sprite_x = 10'd200; sprite_y = 10'd100; mirror = 1'b1;
      pulse_tick(1);
      set_pix(10'd200, 10'd100);
      tick();
      n_tests++;
      if (rom_address !== 15'd39) begin
         n_fail++; $display("FAIL mirror_left: got %0d expected 39", rom_address);
      end
      set_pix(10'd279, 10'd102);
      tick();
      n_tests++;
      if (rom_address !== 15'd40) begin
         n_fail++; $display("FAIL mirror_right: got %0d expected 40", rom_address);
      end
      mirror = 1'b0;
      pulse_tick(1);
      set_pix(10'd200, 10'd100);
      tick();
      n_tests++;
      if (rom_address !== 15'd0) begin
         n_fail++; $display("FAIL mirror_off: got %0d expected 0", rom_address);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_latch_address();
      test_composite();
      test_animation();
      test_clipping();
      test_reset_midline();
`ifdef MIRROR_EN
      test_mirror();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
